// File: rtl/noc_client_injector_if.sv
// -----------------------------------------------------------------------------
// noc_client_injector_if
// Bundles the client-side flit handshake and the NoC-side per-VC valid/credit
// bus of the client injector. Signal names are from the injector's point of
// view (i_* enter the injector, o_* leave it).
//
//   i_v / o_rdy     client flit handshake, transfer when i_v & o_rdy
//   i_dest, i_d     destination address and payload of the offered flit
//   i_last          last flit of the packet
//   i_vc            VC select, meaningful on head flits only
//   o_noc_v         one-hot per-VC flit valid (one cycle per flit)
//   o_noc_d         {last, dest, data}
//   i_noc_credit    per-VC credit return pulses
//   o_idle, o_err   status
//
// Modports: slave = the injector, master = client plus downstream switch.
// -----------------------------------------------------------------------------
interface noc_client_injector_if #(
  parameter int A_W  = 4,
  parameter int D_W  = 8,
  parameter int VC_W = 2
);
  localparam int VCI_W = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic                 i_v;
  logic                 o_rdy;
  logic [A_W-1:0]       i_dest;
  logic [D_W-1:0]       i_d;
  logic                 i_last;
  logic [VCI_W-1:0]     i_vc;
  logic [VC_W-1:0]      o_noc_v;
  logic [A_W+D_W:0]     o_noc_d;
  logic [VC_W-1:0]      i_noc_credit;
  logic                 o_idle;
  logic                 o_err;

  modport slave (
    input  i_v, i_dest, i_d, i_last, i_vc, i_noc_credit,
    output o_rdy, o_noc_v, o_noc_d, o_idle, o_err
  );

  modport master (
    output i_v, i_dest, i_d, i_last, i_vc, i_noc_credit,
    input  o_rdy, o_noc_v, o_noc_d, o_idle, o_err
  );
endinterface

// File: rtl/noc_client_injector.sv
// -----------------------------------------------------------------------------
// noc_client_injector
// Client-side injection port for the tree NoC. Accepts client flits into a
// single staging register, tags each with a VC (head flit chooses, body flits
// inherit), and sends it on the per-VC one-hot valid bus when the credit
// counter of that VC is non-zero. One credit counter per VC mirrors the free
// space of the downstream switch VC FIFO.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-low reset
//   bus          noc_client_injector_if.slave (client handshake + NoC bus)
//   o_dbg_state  packet FSM state (0 = HEAD, 1 = BODY)
//   o_dbg_cnt    credit counters, VC v at [v*CNT_W +: CNT_W]
//
// Handshake: a client flit transfers on a rising edge where i_v & o_rdy.
// o_rdy is a function of registered state only (never of i_v), so the client
// may hold i_v high and simply watch o_rdy. The NoC side has no ready: a flit
// is only ever presented when a credit for its VC is held.
// -----------------------------------------------------------------------------
module noc_client_injector #(
  parameter int N             = 4,
  parameter int A_W           = 4,
  parameter int D_W           = 8,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  noc_client_injector_if.slave                          bus,
  output logic                                          o_dbg_state,
  output logic [VC_W*($clog2(VC_FIFO_DEPTH)+1)-1:0]     o_dbg_cnt
);
  localparam int VCI_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int CNT_W = $clog2(VC_FIFO_DEPTH) + 1;
  localparam int FW    = A_W + D_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(VC_FIFO_DEPTH - 1);

  localparam logic ST_HEAD = 1'b0;
  localparam logic ST_BODY = 1'b1;

  if (N < 1) begin : g_bad_n
    $error("noc_client_injector: N must be at least 1");
  end

  logic               r_hold_v;
  logic [VCI_W-1:0]   r_hold_vc;
  logic [FW-1:0]      r_hold_word;
  logic               r_state;
  logic [VCI_W-1:0]   r_lock_vc;
  logic [CNT_W-1:0]   r_cnt [VC_W];
  logic [VC_W-1:0]    r_noc_v;
  logic [FW-1:0]      r_noc_d;
  logic               r_err;

  logic               w_hold_has_credit;
  logic [VC_W-1:0]    w_hold_onehot;
  logic               w_send;
  logic               w_rdy;
  logic               w_accept;
  logic [VCI_W-1:0]   w_sel_vc;
  logic [VC_W-1:0]    w_cnt_dec;
  logic               w_all_init;

  // Decode the staged VC by comparison rather than array indexing so that a
  // VC_W that is not a power of two never indexes past the counter array.
  always_comb begin
    w_hold_has_credit = 1'b0;
    w_hold_onehot     = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (r_hold_vc == VCI_W'(v)) begin
        w_hold_onehot[v]  = 1'b1;
        w_hold_has_credit = (r_cnt[v] != '0);
      end
    end
  end

  assign w_send    = r_hold_v & w_hold_has_credit;
  assign w_rdy     = ~r_hold_v | w_send;
  assign w_accept  = bus.i_v & w_rdy;
  assign w_sel_vc  = (r_state == ST_HEAD) ? bus.i_vc : r_lock_vc;
  assign w_cnt_dec = w_hold_onehot & {VC_W{w_send}};

  always_comb begin
    w_all_init = 1'b1;
    for (int v = 0; v < VC_W; v++) begin
      if (r_cnt[v] != CNT_INIT) w_all_init = 1'b0;
    end
  end

  // Staging register: refilled in the same cycle it is sent, which gives
  // one flit per cycle while credits last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_v    <= 1'b0;
      r_hold_vc   <= '0;
      r_hold_word <= '0;
    end else if (w_accept) begin
      r_hold_v    <= 1'b1;
      r_hold_vc   <= w_sel_vc;
      r_hold_word <= {bus.i_last, bus.i_dest, bus.i_d};
    end else if (w_send) begin
      r_hold_v    <= 1'b0;
    end
  end

  // Packet FSM: the head flit picks the VC, body flits reuse it so a packet
  // never straddles VCs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_HEAD;
      r_lock_vc <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_HEAD: begin
          r_lock_vc <= bus.i_vc;
          if (!bus.i_last) r_state <= ST_BODY;
        end
        default: begin
          if (bus.i_last) r_state <= ST_HEAD;
        end
      endcase
    end
  end

  // Credit counters. A send and a credit on the same VC cancel out. A credit
  // arriving at full count means the downstream side returned more than it
  // was given: drop it and flag the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_W; v++) r_cnt[v] <= CNT_INIT;
      r_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (bus.i_noc_credit[v] && !w_cnt_dec[v]) begin
          if (r_cnt[v] == CNT_INIT) r_err <= 1'b1;
          else                      r_cnt[v] <= r_cnt[v] + CNT_W'(1);
        end else if (w_cnt_dec[v] && !bus.i_noc_credit[v]) begin
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        end
      end
    end
  end

  // Registered NoC outputs; data holds its last value between flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_noc_v <= '0;
      r_noc_d <= '0;
    end else if (w_send) begin
      r_noc_v <= w_hold_onehot;
      r_noc_d <= r_hold_word;
    end else begin
      r_noc_v <= '0;
    end
  end

  always_comb begin
    o_dbg_cnt = '0;
    for (int v = 0; v < VC_W; v++) o_dbg_cnt[v*CNT_W +: CNT_W] = r_cnt[v];
  end

  assign o_dbg_state  = r_state;
  assign bus.o_rdy    = w_rdy;
  assign bus.o_noc_v  = r_noc_v;
  assign bus.o_noc_d  = r_noc_d;
  assign bus.o_idle   = ~r_hold_v & w_all_init;
  assign bus.o_err    = r_err;

endmodule

// File: tb/tb_noc_client_injector.sv
// -----------------------------------------------------------------------------
// tb_noc_client_injector
// Bench for noc_client_injector with VC_W=2, VC_FIFO_DEPTH=4. A transaction
// level model (queue of accepted flits, integer credit pool per VC, packet
// VC tracking) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_noc_client_injector;
  localparam int A_W   = 4;
  localparam int D_W   = 8;
  localparam int VC_W  = 2;
  localparam int DEPTH = 4;
  localparam int VCI_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FW    = A_W + D_W + 1;
  localparam int EW    = VCI_W + FW;
  localparam int MAXC  = DEPTH - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  noc_client_injector_if #(.A_W(A_W), .D_W(D_W), .VC_W(VC_W)) bus ();
  logic                  dbg_state;
  logic [VC_W*CNT_W-1:0] dbg_cnt;

  noc_client_injector #(
    .N(4), .A_W(A_W), .D_W(D_W), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state),
    .o_dbg_cnt(dbg_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0]   exp_q[$];     // accepted, not yet sent: {vc, last, dest, data}
  int              cred [VC_W];
  int              occ  [VC_W];  // flits held by the downstream model
  int              pulses [VC_W];
  int              accepts;
  logic            in_pkt;
  logic [VCI_W-1:0] pkt_vc;
  logic            err_m;
  logic [FW-1:0]   last_d;
  logic            exp_rdy;
  int              n_checks;
  int              n_errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic model_idle();
    logic r;
    r = (exp_q.size() == 0);
    for (int v = 0; v < VC_W; v++) if (cred[v] != MAXC) r = 1'b0;
    return r;
  endfunction

  function automatic logic front_has_credit();
    logic [EW-1:0]    f;
    logic [VCI_W-1:0] fvc;
    if (exp_q.size() == 0) return 1'b0;
    f   = exp_q[0];
    fvc = f[EW-1 -: VCI_W];
    return cred[fvc] > 0;
  endfunction

  task automatic check_status(input string ph);
    chk({ph, "_rdy"},  {31'd0, bus.o_rdy},  {31'd0, exp_rdy});
    chk({ph, "_err"},  {31'd0, bus.o_err},  {31'd0, err_m});
    chk({ph, "_idle"}, {31'd0, bus.o_idle}, {31'd0, model_idle()});
    for (int v = 0; v < VC_W; v++)
      chk({ph, "_cnt"}, 32'(dbg_cnt[v*CNT_W +: CNT_W]), 32'(cred[v]));
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic [A_W-1:0] dest, input logic [D_W-1:0] d,
                       input logic last, input logic [VCI_W-1:0] vc, input logic [VC_W-1:0] cr);
    logic             rdy_pre;
    logic [EW-1:0]    f;
    logic [VCI_W-1:0] fvc;
    logic [VCI_W-1:0] use_vc;
    logic [VC_W-1:0]  exp_nv;
    bus.i_v = v; bus.i_dest = dest; bus.i_d = d; bus.i_last = last;
    bus.i_vc = vc; bus.i_noc_credit = cr;
    rdy_pre = exp_rdy;
    @(posedge clk);
    #1;
    // send: the oldest accepted flit leaves when its VC has credit
    exp_nv = '0;
    if (front_has_credit()) begin
      f   = exp_q.pop_front();
      fvc = f[EW-1 -: VCI_W];
      exp_nv[fvc] = 1'b1;
      cred[fvc]--;
      occ[fvc]++;
      pulses[fvc]++;
      last_d = f[FW-1:0];
    end
    chk("noc_v", 32'(bus.o_noc_v), 32'(exp_nv));
    chk("noc_d", 32'(bus.o_noc_d), 32'(last_d));
    // accept: head chooses VC, body inherits it
    if (v && rdy_pre) begin
      use_vc = in_pkt ? pkt_vc : vc;
      pkt_vc = use_vc;
      in_pkt = !last;
      exp_q.push_back({use_vc, last, dest, d});
      accepts++;
    end
    // credit returns, saturating with sticky error
    for (int i = 0; i < VC_W; i++) begin
      if (cr[i]) begin
        if (cred[i] == MAXC) err_m = 1'b1;
        else                 cred[i]++;
      end
    end
    exp_rdy = (exp_q.size() == 0) || front_has_credit();
    check_status("cyc");
  endtask

  task automatic idle_cycle(input logic [VC_W-1:0] cr);
    cycle(1'b0, '0, '0, 1'b0, '0, cr);
  endtask

  task automatic send_flit(input logic last, input logic [VCI_W-1:0] vc, input logic [VC_W-1:0] cr);
    cycle(1'b1, A_W'($urandom), D_W'($urandom), last, vc, cr);
  endtask

  // downstream model returns credits for what it holds, then expect idle
  task automatic drain();
    logic [VC_W-1:0] cr;
    for (int i = 0; i < 60; i++) begin
      if (model_idle()) break;
      cr = '0;
      for (int v = 0; v < VC_W; v++) if (occ[v] > 0) begin cr[v] = 1'b1; occ[v]--; end
      idle_cycle(cr);
    end
    chk("drain_idle", {31'd0, bus.o_idle}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_v = 1'b0; bus.i_dest = '0; bus.i_d = '0; bus.i_last = 1'b0;
    bus.i_vc = '0; bus.i_noc_credit = '0;
    exp_q.delete();
    for (int v = 0; v < VC_W; v++) begin cred[v] = MAXC; occ[v] = 0; end
    in_pkt = 1'b0; pkt_vc = '0; err_m = 1'b0; last_d = '0; exp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_noc_v", 32'(bus.o_noc_v), 32'd0);
      chk("rst_noc_d", 32'(bus.o_noc_d), 32'd0);
    end
    rst = 1'b1;
    #2;
    chk("rel_noc_v", 32'(bus.o_noc_v), 32'd0);
    chk("rel_noc_d", 32'(bus.o_noc_d), 32'd0);
    check_status("rel");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, p1, acc0;
    logic [VC_W-1:0] cr;
    n_checks = 0; n_errors = 0; accepts = 0;
    for (int v = 0; v < VC_W; v++) pulses[v] = 0;
    rst = 1'b1;
    #3;
    do_reset();

    // credit exhaustion on VC0 with i_v held high
    p0 = pulses[0]; acc0 = accepts;
    for (int i = 0; i < 8; i++) send_flit(1'b1, 1'b0, '0);
    chk("exh_pulses", 32'(pulses[0] - p0), 32'd3);
    chk("exh_accepts", 32'(accepts - acc0), 32'd4);
    chk("exh_rdy", {31'd0, bus.o_rdy}, 32'd0);
    send_flit(1'b1, 1'b0, 2'b01);
    send_flit(1'b1, 1'b0, 2'b00);
    chk("exh_release", 32'(pulses[0] - p0), 32'd4);
    occ[0] = 4;
    drain();

    // VC lock: head on VC1, body flits request VC0
    p0 = pulses[0]; p1 = pulses[1];
    send_flit(1'b0, 1'b1, '0);
    send_flit(1'b0, 1'b0, '0);
    send_flit(1'b1, 1'b0, '0);
    idle_cycle('0);
    idle_cycle('0);
    chk("lock_vc1", 32'(pulses[1] - p1), 32'd3);
    chk("lock_vc0", 32'(pulses[0] - p0), 32'd0);
    chk("lock_cnt1", 32'(dbg_cnt[CNT_W +: CNT_W]), 32'd0);
    chk("lock_cnt0", 32'(dbg_cnt[0 +: CNT_W]), 32'd3);
    send_flit(1'b1, 1'b0, '0);
    idle_cycle('0);
    chk("lock_next_vc0", 32'(pulses[0] - p0), 32'd1);
    drain();

    // send and credit in the same cycle on VC0
    send_flit(1'b1, 1'b0, '0);
    idle_cycle('0);
    send_flit(1'b1, 1'b0, '0);
    occ[0]--;
    idle_cycle(2'b01);
    chk("same_cyc_cnt0", 32'(dbg_cnt[0 +: CNT_W]), 32'd2);
    drain();

    // a VC1 credit does not release a VC0 stall
    send_flit(1'b1, 1'b1, '0);
    for (int i = 0; i < 4; i++) send_flit(1'b1, 1'b0, '0);
    idle_cycle('0);
    p0 = pulses[0];
    occ[1]--;
    idle_cycle(2'b10);
    idle_cycle('0);
    chk("stall_rdy", {31'd0, bus.o_rdy}, 32'd0);
    chk("stall_pulses", 32'(pulses[0] - p0), 32'd0);
    drain();

    // credit overflow on VC1
    idle_cycle(2'b10);
    chk("ovf_err", {31'd0, bus.o_err}, 32'd1);
    chk("ovf_cnt1", 32'(dbg_cnt[CNT_W +: CNT_W]), 32'd3);
    for (int i = 0; i < 4; i++) send_flit(1'b1, 1'(i), '0);
    drain();
    chk("ovf_sticky", {31'd0, bus.o_err}, 32'd1);

    // reset with a head flit staged
    p0 = pulses[0]; p1 = pulses[1];
    send_flit(1'b0, 1'b1, '0);
    do_reset();
    idle_cycle('0);
    chk("mid_rst_pulses", 32'(pulses[0] + pulses[1] - p0 - p1), 32'd0);
    send_flit(1'b0, 1'b0, '0);
    send_flit(1'b0, 1'b1, '0);
    send_flit(1'b1, 1'b1, '0);
    idle_cycle('0);
    idle_cycle('0);
    chk("mid_rst_vc0", 32'(pulses[0] - p0), 32'd3);
    chk("mid_rst_last", {31'd0, bus.o_noc_d[FW-1]}, 32'd1);
    drain();

    // randomized traffic with a well-behaved downstream
    for (int i = 0; i < 1500; i++) begin
      cr = '0;
      for (int v = 0; v < VC_W; v++)
        if (occ[v] > 0 && $urandom_range(0, 2) == 0) begin cr[v] = 1'b1; occ[v]--; end
      cycle($urandom_range(0, 3) != 0, A_W'($urandom), D_W'($urandom),
            $urandom_range(0, 2) == 0, VCI_W'($urandom_range(0, VC_W - 1)), cr);
    end
    drain();
    chk("final_err", {31'd0, bus.o_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
